stack_unit: RTL

Parametrised LIFO operand stack for the stack-based multi-cycle MIPS datapath. It holds up to DEPTH words of WIDTH bits and supports push, pop, replace-top and flush commands. It exposes the top two entries combinationally to the ALU operand path. Occupancy flags and sticky overflow/underflow error flags are reported to the controller.

---
 rtl/stack_unit.sv | 52 +++++
 1 files changed

// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack exposing the top two entries, with occupancy and sticky error flags
module stack_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    wr_idx;
    logic             wr, inc, dec, ovf_set, unf_set;
    assign count   = sp;
    assign empty   = sp == '0;
    assign full    = sp == CW'(DEPTH);
    // array contents are never reset, so reads are gated by occupancy
    assign tos     = empty ? '0 : mem[AW'(sp - CW'(1))];
    assign nos     = sp < CW'(2) ? '0 : mem[AW'(sp - CW'(2))];
    assign inc     = !flush && push && !pop && !full;
    assign dec     = !flush && !push && pop && !empty;
    assign wr      = !flush && push && (pop ? !empty : !full);
    assign wr_idx  = AW'(pop ? sp - CW'(1) : sp);
    assign ovf_set = !flush && push && !pop && full;
    assign unf_set = !flush && pop && empty;
    always_ff @(posedge clk)
        if (wr) mem[wr_idx] <= data;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            sp  <= flush ? '0 : inc ? sp + CW'(1) : dec ? sp - CW'(1) : sp;
            ovf <= ovf_set || (ovf && !clr_err);
            unf <= unf_set || (unf && !clr_err);
        end
    end
endmodule
